// File: rtl/zap_pipe_fifo_pkg.sv
// Shared types for the zap_pipe_fifo pipe buffer: control action encoding
// and the occupancy-width helper used by the top and the bench.
package zap_pipe_fifo_pkg;

  typedef enum logic [1:0] {
    ACT_ADV  = 2'd0,
    ACT_HOLD = 2'd1,
    ACT_CLR  = 2'd2
  } ctl_action_t;

  // Occupancy needs one extra bit so that a full FIFO (level == depth) is representable.
  function automatic int lvl_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/zap_pipe_fifo_pri.sv
// Clear/stall priority resolver: picks one pipe action from NCTL-level
// clr/stl request vectors, bit NCTL-1 most important, clr before stl per level.
module zap_pipe_fifo_pri
  import zap_pipe_fifo_pkg::*;
#(
  parameter int NCTL = 4
) (
  input  logic [NCTL-1:0] clr,
  input  logic [NCTL-1:0] stl,
  output ctl_action_t     action
);

  // Ascending scan where later levels overwrite earlier ones is equivalent to a
  // top-down first-match scan; the if/else gives clr precedence within a level.
  always_comb begin
    action = ACT_ADV;
    for (int k = 0; k < NCTL; k++) begin
      if (clr[k]) begin
        action = ACT_CLR;
      end else if (stl[k]) begin
        action = ACT_HOLD;
      end
    end
  end

endmodule

// File: rtl/zap_pipe_fifo.sv
// Clearable, stallable pipe FIFO with registered output and occupancy flags.
// Optional empty-FIFO bypass enabled by defining ZAP_PIPE_FIFO_BYPASS_EN.
module zap_pipe_fifo
  import zap_pipe_fifo_pkg::*;
#(
  parameter int WDT       = 32,
  parameter int DEPTH     = 8,
  parameter int NCTL      = 4,
  parameter int AF_THRESH = DEPTH - 2
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic [NCTL-1:0]             i_clr,
  input  logic [NCTL-1:0]             i_stl,
  input  logic                        i_write_inhibit,
  input  logic                        i_valid,
  input  logic [WDT-1:0]              i_instr,
  output logic                        o_full,
  output logic                        o_almost_full,
  output logic [lvl_width(DEPTH)-1:0] o_level,
  output logic                        o_valid,
  output logic [WDT-1:0]              o_instr
);

  localparam int PW = lvl_width(DEPTH);
  localparam int AW = PW - 1;

  logic [1:0]     rst_sync;
  logic           rst_int_n;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  level;
  logic [WDT-1:0] mem [DEPTH];
  logic           empty;
  logic           full;
  logic           we;
  logic           bypass;
  logic           store;
  ctl_action_t    action;

  // Reset asserts asynchronously but releases two clocks later, aligned to i_clk.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync[1];

  zap_pipe_fifo_pri #(
    .NCTL (NCTL)
  ) u_pri (
    .clr    (i_clr),
    .stl    (i_stl),
    .action (action)
  );

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

  assign we = i_valid & ~i_write_inhibit & ~full & (action != ACT_CLR);

`ifdef ZAP_PIPE_FIFO_BYPASS_EN
  assign bypass = empty & (action == ACT_ADV) & we;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed payload goes straight to the output register and is never stored.
  assign store = we & ~bypass;

  always_ff @(posedge i_clk) begin
    if (store) begin
      mem[wr_ptr[AW-1:0]] <= i_instr;
    end
  end

  always_ff @(posedge i_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_valid <= 1'b0;
      o_instr <= '0;
    end else begin
      case (action)
        ACT_CLR: begin
          wr_ptr  <= '0;
          rd_ptr  <= '0;
          o_valid <= 1'b0;
        end
        ACT_HOLD: begin
          if (store) begin
            wr_ptr <= wr_ptr + PW'(1);
          end
        end
        default: begin
          if (store) begin
            wr_ptr <= wr_ptr + PW'(1);
          end
          if (!empty) begin
            o_instr <= mem[rd_ptr[AW-1:0]];
            o_valid <= 1'b1;
            rd_ptr  <= rd_ptr + PW'(1);
          end else if (bypass) begin
            o_instr <= i_instr;
            o_valid <= 1'b1;
          end else begin
            o_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  assign o_full        = full;
  assign o_almost_full = (level >= PW'(AF_THRESH));
  assign o_level       = level;

endmodule

// File: tb/tb_zap_pipe_fifo.sv
// Self-checking bench for zap_pipe_fifo: queue model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_zap_pipe_fifo;
  import zap_pipe_fifo_pkg::*;

  localparam int WDT = 32;
  localparam int DEPTH = 8;
  localparam int NCTL = 4;
  localparam int AF_THRESH = DEPTH - 2;
  localparam int PW = lvl_width(DEPTH);

  logic            i_clk = 1'b0;
  logic            i_reset_n = 1'b0;
  logic [NCTL-1:0] i_clr = '0;
  logic [NCTL-1:0] i_stl = '0;
  logic            i_write_inhibit = 1'b0;
  logic            i_valid = 1'b0;
  logic [WDT-1:0]  i_instr = '0;
  logic            o_full;
  logic            o_almost_full;
  logic [PW-1:0]   o_level;
  logic            o_valid;
  logic [WDT-1:0]  o_instr;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  logic [WDT-1:0] q[$];
  logic           m_valid = 1'b0;
  logic [WDT-1:0] m_instr = '0;

  zap_pipe_fifo #(
    .WDT       (WDT),
    .DEPTH     (DEPTH),
    .NCTL      (NCTL),
    .AF_THRESH (AF_THRESH)
  ) dut (
    .i_clk           (i_clk),
    .i_reset_n       (i_reset_n),
    .i_clr           (i_clr),
    .i_stl           (i_stl),
    .i_write_inhibit (i_write_inhibit),
    .i_valid         (i_valid),
    .i_instr         (i_instr),
    .o_full          (o_full),
    .o_almost_full   (o_almost_full),
    .o_level         (o_level),
    .o_valid         (o_valid),
    .o_instr         (o_instr)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // 0 = advance, 1 = hold, 2 = clear: first asserted request from the top level down.
  function automatic int model_action(input logic [NCTL-1:0] c, input logic [NCTL-1:0] s);
    for (int k = NCTL - 1; k >= 0; k--) begin
      if (c[k]) return 2;
      if (s[k]) return 1;
    end
    return 0;
  endfunction

  always @(negedge i_reset_n) begin
    q.delete();
    m_valid = 1'b0;
    m_instr = '0;
  end

  always @(posedge i_clk) begin
    if (i_reset_n) begin
      int  act;
      bit  wr;
      act = model_action(i_clr, i_stl);
      wr  = i_valid && !i_write_inhibit && (q.size() < DEPTH) && (act != 2);
      if (act == 2) begin
        q.delete();
        m_valid = 1'b0;
      end else if (act == 1) begin
        if (wr) q.push_back(i_instr);
      end else if (q.size() > 0) begin
        m_instr = q.pop_front();
        m_valid = 1'b1;
        if (wr) q.push_back(i_instr);
      end else begin
`ifdef ZAP_PIPE_FIFO_BYPASS_EN
        if (wr) begin
          m_instr = i_instr;
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
`else
        m_valid = 1'b0;
        if (wr) q.push_back(i_instr);
`endif
      end
    end
  end

  always @(negedge i_clk) begin
    if (cmp_en) begin
      chk("cyc_valid", 32'(o_valid), 32'(m_valid));
      chk("cyc_instr", o_instr, m_instr);
      chk("cyc_level", 32'(o_level), q.size());
      chk("cyc_full", 32'(o_full), 32'(q.size() == DEPTH));
      chk("cyc_afull", 32'(o_almost_full), 32'(q.size() >= AF_THRESH));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_clr = '0;
    i_stl = '0;
    i_write_inhibit = 1'b0;
    i_valid = 1'b0;
    i_instr = '0;
  endtask

  task automatic push_hold(input logic [WDT-1:0] v);
    i_clr = '0;
    i_stl = 4'b0001;
    i_valid = 1'b1;
    i_instr = v;
    step();
  endtask

  initial begin
    idle();
    repeat (3) step();
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_instr", o_instr, 0);
    chk("rst_level", 32'(o_level), 0);
    chk("rst_full", 32'(o_full), 0);
    chk("rst_afull", 32'(o_almost_full), 0);
    i_reset_n = 1'b1;
    repeat (3) step();
    cmp_en = 1'b1;

    // bypass / plain latency into an empty FIFO
    i_valid = 1'b1;
    i_instr = 32'h55;
    step();
    idle();
`ifdef ZAP_PIPE_FIFO_BYPASS_EN
    chk("byp_valid", 32'(o_valid), 1);
    chk("byp_instr", o_instr, 32'h55);
    chk("byp_level", 32'(o_level), 0);
`else
    chk("nobyp_valid0", 32'(o_valid), 0);
    chk("nobyp_level", 32'(o_level), 1);
    step();
    chk("nobyp_valid1", 32'(o_valid), 1);
    chk("nobyp_instr", o_instr, 32'h55);
    chk("nobyp_level0", 32'(o_level), 0);
`endif
    step();
    chk("byp_drain", 32'(o_valid), 0);

    // fill under stall, overflow write dropped
    for (int v = 1; v <= 8; v++) begin
      push_hold(32'(v));
      chk("fill_level", 32'(o_level), 32'(v));
      chk("fill_afull", 32'(o_almost_full), 32'(v >= 6));
      chk("fill_full", 32'(o_full), 32'(v == 8));
    end
    push_hold(32'h9);
    chk("ovf_level", 32'(o_level), 8);
    chk("ovf_full", 32'(o_full), 1);
    idle();
    for (int v = 1; v <= 8; v++) begin
      step();
      chk("drain_instr", o_instr, 32'(v));
      chk("drain_valid", 32'(o_valid), 1);
      chk("drain_level", 32'(o_level), 32'(8 - v));
    end
    step();
    chk("drain_end", 32'(o_valid), 0);

    // write inhibit
    i_valid = 1'b1;
    i_write_inhibit = 1'b1;
    i_instr = 32'h77;
    step();
    idle();
    chk("inh_level", 32'(o_level), 0);
    step();
    chk("inh_valid", 32'(o_valid), 0);

    // priority resolution
    push_hold(32'h10);
    push_hold(32'h11);
    push_hold(32'h12);
    idle();
    step();
    chk("pri_pop", o_instr, 32'h10);
    chk("pri_lvl2", 32'(o_level), 2);
    i_stl = 4'b1000;
    i_clr = 4'b0100;
    repeat (2) step();
    chk("pri_hold_lvl", 32'(o_level), 2);
    chk("pri_hold_val", 32'(o_valid), 1);
    chk("pri_hold_ins", o_instr, 32'h10);
    i_stl = 4'b1000;
    i_clr = 4'b1000;
    step();
    chk("pri_clr_lvl", 32'(o_level), 0);
    chk("pri_clr_val", 32'(o_valid), 0);
    push_hold(32'h20);
    push_hold(32'h21);
    idle();
    step();
    chk("pri_pop2", o_instr, 32'h20);
    i_clr = 4'b0001;
    step();
    idle();
    chk("pri_clr0_val", 32'(o_valid), 0);
    chk("pri_clr0_lvl", 32'(o_level), 0);

    // clear plus same-cycle write
    push_hold(32'h30);
    push_hold(32'h31);
    push_hold(32'h32);
    chk("cw_lvl3", 32'(o_level), 3);
    i_stl = '0;
    i_clr = 4'b0010;
    i_valid = 1'b1;
    i_instr = 32'hAA;
    step();
    idle();
    chk("cw_lvl0", 32'(o_level), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("cw_valid", 32'(o_valid), 0);
      chk("cw_instr", o_instr, 32'h20);
    end

    // wrap-around with simultaneous write/pop
    for (int v = 0; v < 4; v++) push_hold(32'(v));
    i_stl = '0;
    for (int i = 0; i < 20; i++) begin
      i_valid = 1'b1;
      i_instr = 32'(i + 4);
      step();
      chk("wrap_instr", o_instr, 32'(i));
      chk("wrap_level", 32'(o_level), 4);
    end
    idle();
    for (int i = 20; i < 24; i++) begin
      step();
      chk("wrap_drain", o_instr, 32'(i));
    end
    step();
    chk("wrap_end", 32'(o_valid), 0);

    // asynchronous reset mid-stream at level 5
    for (int v = 0; v < 5; v++) push_hold(32'h40 + 32'(v));
    i_valid = 1'b0;
    chk("ar_lvl5", 32'(o_level), 5);
    #3;
    i_reset_n = 1'b0;
    #1;
    chk("ar_valid", 32'(o_valid), 0);
    chk("ar_instr", o_instr, 0);
    chk("ar_level", 32'(o_level), 0);
    chk("ar_full", 32'(o_full), 0);
    chk("ar_afull", 32'(o_almost_full), 0);
    idle();
    repeat (2) step();
    i_reset_n = 1'b1;
    repeat (4) step();
    chk("ar_post_lvl", 32'(o_level), 0);
    chk("ar_post_val", 32'(o_valid), 0);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
